// File: rtl/main_mem_timed.sv
// Block-granular main memory with fixed multi-cycle latency and valid/ready on both sides.
// Optional per-word write mask: define MAIN_MEM_WMASK_EN to add the req_wmask port.
module main_mem_timed #(
    parameter int ADDR_W      = 10,
    parameter int WORD_W      = 32,
    parameter int WPB         = 4,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [WORD_W*WPB-1:0] req_wdata,
`ifdef MAIN_MEM_WMASK_EN
    input  logic [WPB-1:0]        req_wmask,
`endif
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WORD_W*WPB-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int OFF   = $clog2(WORD_W / 8 * WPB);
    localparam int IDX_W = ADDR_W - OFF;
    localparam int BLK_W = WORD_W * WPB;
    localparam int MW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               enter_resp;

    logic               wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic               oor_q;
    logic [BLK_W-1:0]   wdata_q;
    logic [WPB-1:0]     mask_q;
    logic [BLK_W-1:0]   rdata_q;
    logic               err_q;

    logic [IDX_W-1:0]   req_idx;
    logic               req_oor;
    logic [WPB-1:0]     req_mask;
    logic [BLK_W-1:0]   rd_blk;
    logic [WORD_W-1:0]  mem_w [DEPTH_WORDS];
    logic               unused_off;

    assign req_idx    = req_addr[ADDR_W-1:OFF];
    assign req_oor    = (int'(req_idx) * WPB) >= DEPTH_WORDS;
    assign unused_off = ^req_addr[OFF-1:0];

`ifdef MAIN_MEM_WMASK_EN
    assign req_mask = req_wmask;
`else
    assign req_mask = '1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter is loaded so that RESP is entered exactly LATENCY edges after accept.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= req_write;
                idx_q   <= req_idx;
                oor_q   <= req_oor;
                wdata_q <= req_wdata;
                mask_q  <= req_mask;
            end
            if (enter_resp) begin
                err_q   <= oor_q;
                rdata_q <= (wr_q || oor_q) ? '0 : rd_blk;
            end
        end
    end

    always_comb begin
        rd_blk = '0;
        for (int w = 0; w < WPB; w++) begin
            rd_blk[w*WORD_W +: WORD_W] = mem_w[MW'(int'(idx_q) * WPB + w)];
        end
    end

    // Storage has no reset: contents start as their own word index and survive reset.
    for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
        logic [WORD_W-1:0] word_q = WORD_W'(g);
        logic              we;

        assign we = enter_resp && wr_q && !oor_q
                    && (int'(idx_q) == g / WPB)
                    && mask_q[g % WPB];

        always_ff @(posedge clk) begin
            if (we) begin
                word_q <= wdata_q[(g % WPB)*WORD_W +: WORD_W];
            end
        end

        assign mem_w[g] = word_q;
    end

endmodule
